// File: rtl/mandelbrot_pkg.sv
// Shared types for the Mandelbrot pipeline: coordinate format and scheduler states.
package mandelbrot_pkg;

   localparam int INTEGER_BITS    = 8;
   localparam int FRACTIONAL_BITS = 24;
   localparam int DATA_WIDTH      = INTEGER_BITS + FRACTIONAL_BITS;

   typedef logic signed [DATA_WIDTH-1:0] coord_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      OUTPUT
   } sched_state_e;

endpackage

// File: rtl/mandelbrot_coord_stepper.sv
// Raster position tracker: column/row counters and the matching complex-plane x/y accumulators.
module mandelbrot_coord_stepper #(
   parameter int DW        = 32,
   parameter int DIM_WIDTH = 12
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 init,
   input  logic                 advance,
   input  logic signed [DW-1:0] x_min,
   input  logic signed [DW-1:0] y_max,
   input  logic signed [DW-1:0] step,
   input  logic [DIM_WIDTH-1:0] width,
   input  logic [DIM_WIDTH-1:0] height,
   output logic [DIM_WIDTH-1:0] col,
   output logic [DIM_WIDTH-1:0] row,
   output logic signed [DW-1:0] x,
   output logic signed [DW-1:0] y,
   output logic                 last
);

   logic signed [DW-1:0] x_min_q;
   logic signed [DW-1:0] step_q;
   logic [DIM_WIDTH-1:0] width_q;
   logic [DIM_WIDTH-1:0] height_q;
   logic                 col_end;

   assign col_end = (col == width_q - DIM_WIDTH'(1));
   assign last    = col_end && (row == height_q - DIM_WIDTH'(1));

   // Coordinates wrap in two's complement; the frame is expected to stay in range.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         x_min_q  <= '0;
         step_q   <= '0;
         width_q  <= '0;
         height_q <= '0;
         col      <= '0;
         row      <= '0;
         x        <= '0;
         y        <= '0;
      end else if (init) begin
         x_min_q  <= x_min;
         step_q   <= step;
         width_q  <= width;
         height_q <= height;
         col      <= '0;
         row      <= '0;
         x        <= x_min;
         y        <= y_max;
      end else if (advance) begin
         if (col_end) begin
            col <= '0;
            x   <= x_min_q;
            row <= row + DIM_WIDTH'(1);
            y   <= y - step_q;
         end else begin
            col <= col + DIM_WIDTH'(1);
            x   <= x + step_q;
         end
      end
   end

endmodule

// File: rtl/mandelbrot_pixel_scheduler.sv
// Feeds the iteration core one pixel at a time in raster order and streams {col,row,iter} out.
module mandelbrot_pixel_scheduler #(
   parameter int INTEGER_BITS    = 8,
   parameter int FRACTIONAL_BITS = 24,
   parameter int MAX_ITER_WIDTH  = 16,
   parameter int DIM_WIDTH       = 12,
   localparam int DW             = INTEGER_BITS + FRACTIONAL_BITS
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      frame_start_i,
   input  logic signed [DW-1:0]      x_min_i,
   input  logic signed [DW-1:0]      y_max_i,
   input  logic signed [DW-1:0]      step_i,
   input  logic [DIM_WIDTH-1:0]      width_i,
   input  logic [DIM_WIDTH-1:0]      height_i,
   input  logic [MAX_ITER_WIDTH-1:0] max_iter_i,
   output logic                      core_start_o,
   output logic signed [DW-1:0]      core_x0_o,
   output logic signed [DW-1:0]      core_y0_o,
   output logic [MAX_ITER_WIDTH-1:0] core_max_iter_o,
   input  logic [MAX_ITER_WIDTH-1:0] core_iter_i,
   input  logic                      core_done_i,
   output logic                      pix_valid_o,
   input  logic                      pix_ready_i,
   output logic [DIM_WIDTH-1:0]      pix_col_o,
   output logic [DIM_WIDTH-1:0]      pix_row_o,
   output logic [MAX_ITER_WIDTH-1:0] pix_iter_o,
   output logic                      pix_last_o,
   output logic                      busy_o,
   output logic                      frame_done_o
);

   import mandelbrot_pkg::*;

   // state  | meaning
   // IDLE   | no frame running; accepts frame_start_i
   // ISSUE  | pulse core_start_o for the current pixel
   // WAIT   | core running; core_done_i is trusted from here on
   // OUTPUT | result presented on pix_*, waiting for pix_ready_i

   sched_state_e state_q, state_d;

   logic                      accept, empty_frame, capture, advance, finish;
   logic                      last;
   logic [DIM_WIDTH-1:0]      col, row;
   logic signed [DW-1:0]      x, y;
   logic [MAX_ITER_WIDTH-1:0] max_iter_q, pix_iter_q;
   logic                      pix_valid_q, busy_q, frame_done_q;

   mandelbrot_coord_stepper #(
      .DW        (DW),
      .DIM_WIDTH (DIM_WIDTH)
   ) u_stepper (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .init    (accept),
      .advance (advance),
      .x_min   (x_min_i),
      .y_max   (y_max_i),
      .step    (step_i),
      .width   (width_i),
      .height  (height_i),
      .col     (col),
      .row     (row),
      .x       (x),
      .y       (y),
      .last    (last)
   );

   // A start landing on the frame_done_o cycle is dropped along with starts while busy.
   always_comb begin
      state_d      = state_q;
      core_start_o = 1'b0;
      accept       = 1'b0;
      empty_frame  = 1'b0;
      capture      = 1'b0;
      advance      = 1'b0;
      finish       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (frame_start_i && !frame_done_q) begin
               accept = 1'b1;
               if (width_i == '0 || height_i == '0) empty_frame = 1'b1;
               else                                 state_d     = ISSUE;
            end
         end
         ISSUE: begin
            core_start_o = 1'b1;
            state_d      = WAIT;
         end
         WAIT: begin
            if (core_done_i) begin
               capture = 1'b1;
               state_d = OUTPUT;
            end
         end
         OUTPUT: begin
            if (pix_ready_i) begin
               if (last) begin
                  finish  = 1'b1;
                  state_d = IDLE;
               end else begin
                  advance = 1'b1;
                  state_d = ISSUE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         max_iter_q   <= '0;
         pix_iter_q   <= '0;
         pix_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         frame_done_q <= finish | empty_frame;
         if (accept) max_iter_q <= max_iter_i;
         if (accept && !empty_frame) busy_q <= 1'b1;
         else if (finish)            busy_q <= 1'b0;
         if (capture) begin
            pix_iter_q  <= core_iter_i;
            pix_valid_q <= 1'b1;
         end else if (finish || advance) begin
            pix_valid_q <= 1'b0;
         end
      end
   end

   assign core_x0_o       = x;
   assign core_y0_o       = y;
   assign core_max_iter_o = max_iter_q;
   assign pix_valid_o     = pix_valid_q;
   assign pix_col_o       = col;
   assign pix_row_o       = row;
   assign pix_iter_o      = pix_iter_q;
   assign pix_last_o      = pix_valid_q & last;
   assign busy_o          = busy_q;
   assign frame_done_o    = frame_done_q;

endmodule

// File: tb/tb_mandelbrot_pixel_scheduler.sv
// Bench for the pixel scheduler with a behavioural iteration core and a pixel/coordinate scoreboard.
module tb_mandelbrot_pixel_scheduler;

   localparam int DW       = 32;
   localparam int MW       = 16;
   localparam int DM       = 12;
   localparam int CORE_LAT = 3;

   logic                 clk_i         = 1'b0;
   logic                 rst_i         = 1'b1;
   logic                 frame_start_i = 1'b0;
   logic signed [DW-1:0] x_min_i       = '0;
   logic signed [DW-1:0] y_max_i       = '0;
   logic signed [DW-1:0] step_i        = '0;
   logic [DM-1:0]        width_i       = '0;
   logic [DM-1:0]        height_i      = '0;
   logic [MW-1:0]        max_iter_i    = '0;
   logic                 pix_ready_i   = 1'b1;
   logic                 core_start_o;
   logic signed [DW-1:0] core_x0_o, core_y0_o;
   logic [MW-1:0]        core_max_iter_o;
   logic [MW-1:0]        core_iter_i;
   logic                 core_done_i;
   logic                 pix_valid_o;
   logic [DM-1:0]        pix_col_o, pix_row_o;
   logic [MW-1:0]        pix_iter_o;
   logic                 pix_last_o, busy_o, frame_done_o;

   always #5 clk_i = ~clk_i;

   mandelbrot_pixel_scheduler dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .frame_start_i   (frame_start_i),
      .x_min_i         (x_min_i),
      .y_max_i         (y_max_i),
      .step_i          (step_i),
      .width_i         (width_i),
      .height_i        (height_i),
      .max_iter_i      (max_iter_i),
      .core_start_o    (core_start_o),
      .core_x0_o       (core_x0_o),
      .core_y0_o       (core_y0_o),
      .core_max_iter_o (core_max_iter_o),
      .core_iter_i     (core_iter_i),
      .core_done_i     (core_done_i),
      .pix_valid_o     (pix_valid_o),
      .pix_ready_i     (pix_ready_i),
      .pix_col_o       (pix_col_o),
      .pix_row_o       (pix_row_o),
      .pix_iter_o      (pix_iter_o),
      .pix_last_o      (pix_last_o),
      .busy_o          (busy_o),
      .frame_done_o    (frame_done_o)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int core_starts = 0;
   int frame_dones = 0;
   int pix_count   = 0;

   logic [40:0]   pix_q[$];
   logic [63:0]   coord_q[$];
   logic [MW-1:0] exp_max_iter = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Escape-time reference: iterate z = z^2 + c, stop when |z|^2 >= 4.
   function automatic logic [15:0] mandel_ref(input logic signed [31:0] cr,
                                              input logic signed [31:0] ci,
                                              input logic [15:0] mx);
      longint zr, zi, nzr, nzi, lcr, lci;
      zr  = 0;
      zi  = 0;
      lcr = longint'(cr);
      lci = longint'(ci);
      for (int n = 0; n < int'(mx); n++) begin
         nzr = ((zr * zr - zi * zi) >>> 24) + lcr;
         nzi = ((2 * zr * zi) >>> 24) + lci;
         zr  = nzr;
         zi  = nzi;
         if (((zr * zr + zi * zi) >>> 24) >= (longint'(4) << 24)) return 16'(n);
      end
      return mx;
   endfunction

   int core_cnt;
   always @(posedge clk_i) begin
      if (rst_i) begin
         core_done_i <= 1'b0;
         core_iter_i <= '0;
         core_cnt    <= 0;
      end else if (core_start_o) begin
         core_done_i <= 1'b0;
         core_iter_i <= mandel_ref(core_x0_o, core_y0_o, core_max_iter_o);
         core_cnt    <= CORE_LAT;
      end else if (core_cnt > 0) begin
         core_cnt <= core_cnt - 1;
         if (core_cnt == 1) core_done_i <= 1'b1;
      end
   end

   logic        prev_hold = 1'b0;
   logic [40:0] held      = '0;
   logic [40:0] cur;
   logic [63:0] ce;
   assign cur = {pix_col_o, pix_row_o, pix_iter_o, pix_last_o};

   always @(negedge clk_i) begin
      if (rst_i) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) check("pix_stable", 64'(cur), 64'(held));
         prev_hold = pix_valid_o && !pix_ready_i;
         held      = cur;
         if (pix_valid_o) check("start_while_valid", 64'(core_start_o), 64'(0));
         if (core_start_o) begin
            core_starts++;
            check("coord_expected", 64'(coord_q.size() > 0), 64'(1));
            if (coord_q.size() > 0) begin
               ce = coord_q.pop_front();
               check("core_x0", 64'($unsigned(core_x0_o)), 64'(ce[63:32]));
               check("core_y0", 64'($unsigned(core_y0_o)), 64'(ce[31:0]));
               check("core_max_iter", 64'(core_max_iter_o), 64'(exp_max_iter));
            end
         end
         if (pix_valid_o && pix_ready_i) begin
            pix_count++;
            check("pix_expected", 64'(pix_q.size() > 0), 64'(1));
            if (pix_q.size() > 0) check("pixel", 64'(cur), 64'(pix_q.pop_front()));
         end
         if (frame_done_o) frame_dones++;
      end
   end

   task automatic pulse_start(input logic signed [31:0] xm, input logic signed [31:0] ym,
                              input logic signed [31:0] st, input int w, input int h, input int mi);
      x_min_i       = xm;
      y_max_i       = ym;
      step_i        = st;
      width_i       = DM'(w);
      height_i      = DM'(h);
      max_iter_i    = MW'(mi);
      frame_start_i = 1'b1;
      @(posedge clk_i);
      #1 frame_start_i = 1'b0;
   endtask

   task automatic start_frame(input logic signed [31:0] xm, input logic signed [31:0] ym,
                              input logic signed [31:0] st, input int w, input int h, input int mi);
      logic signed [31:0] x, y;
      y = ym;
      for (int r = 0; r < h; r++) begin
         x = xm;
         for (int c = 0; c < w; c++) begin
            pix_q.push_back({DM'(c), DM'(r), mandel_ref(x, y, MW'(mi)),
                             (r == h - 1) && (c == w - 1)});
            coord_q.push_back({x, y});
            x = x + st;
         end
         y = y - st;
      end
      exp_max_iter = MW'(mi);
      pulse_start(xm, ym, st, w, h, mi);
   endtask

   task automatic wait_frame_done(input int budget);
      bit seen = 1'b0;
      for (int k = 0; k < budget; k++) begin
         if (frame_done_o) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk_i);
         #1;
      end
      check("frame_done_seen", 64'(seen), 64'(1));
   endtask

   task automatic wait_valid(input int budget);
      bit seen = 1'b0;
      for (int k = 0; k < budget; k++) begin
         if (pix_valid_o) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk_i);
         #1;
      end
      check("pix_valid_seen", 64'(seen), 64'(1));
   endtask

   localparam logic signed [31:0] M2 = 32'shFE000000;
   localparam logic signed [31:0] P2 = 32'sh02000000;

   initial begin
      int fd0, cs0, pc0, cs, seen;
      repeat (3) @(posedge clk_i);
      #1;
      check("rst_core_start", 64'(core_start_o), 64'(0));
      check("rst_pix_valid", 64'(pix_valid_o), 64'(0));
      check("rst_busy", 64'(busy_o), 64'(0));
      check("rst_frame_done", 64'(frame_done_o), 64'(0));
      rst_i = 1'b0;

      // 2x2 frame, ready held high
      fd0 = frame_dones; cs0 = core_starts;
      start_frame(M2, 32'sh0, P2, 2, 2, 16);
      check("busy_after_start", 64'(busy_o), 64'(1));
      wait_frame_done(200);
      check("busy_at_done", 64'(busy_o), 64'(0));
      @(posedge clk_i); #1;
      check("frame_done_one_cycle", 64'(frame_done_o), 64'(0));
      check("t1_frames", 64'(frame_dones - fd0), 64'(1));
      check("t1_starts", 64'(core_starts - cs0), 64'(4));
      check("t1_pix_q_empty", 64'(pix_q.size()), 64'(0));

      // same frame with backpressure on pixel 2
      fd0 = frame_dones; cs0 = core_starts;
      pix_ready_i = 1'b0;
      start_frame(M2, 32'sh0, P2, 2, 2, 16);
      for (int k = 0; k < 4; k++) begin
         wait_valid(50);
         if (k == 1) begin
            cs = core_starts;
            repeat (5) @(posedge clk_i);
            #1;
            check("stall_no_start", 64'(core_starts - cs), 64'(0));
         end
         pix_ready_i = 1'b1;
         @(posedge clk_i);
         #1 pix_ready_i = 1'b0;
      end
      wait_frame_done(20);
      pix_ready_i = 1'b1;
      @(posedge clk_i); #1;
      check("t2_frames", 64'(frame_dones - fd0), 64'(1));
      check("t2_starts", 64'(core_starts - cs0), 64'(4));
      check("t2_pix_q_empty", 64'(pix_q.size()), 64'(0));

      // zero-width frame
      fd0 = frame_dones; cs0 = core_starts; pc0 = pix_count;
      start_frame(32'sh0, 32'sh0, P2, 0, 3, 16);
      check("zero_done_next_cycle", 64'(frame_done_o), 64'(1));
      repeat (6) @(posedge clk_i);
      #1;
      check("zero_frames", 64'(frame_dones - fd0), 64'(1));
      check("zero_no_start", 64'(core_starts - cs0), 64'(0));
      check("zero_no_pixels", 64'(pix_count - pc0), 64'(0));

      // restart attempts while busy and on the frame_done cycle
      fd0 = frame_dones; cs0 = core_starts;
      start_frame(M2, 32'sh0, P2, 2, 2, 16);
      repeat (3) @(posedge clk_i);
      #1;
      pulse_start(32'sh0, 32'sh0, P2, 3, 3, 5);
      wait_frame_done(200);
      pulse_start(32'sh0, 32'sh0, P2, 1, 1, 5);
      check("coincident_start_dropped", 64'(busy_o), 64'(0));
      repeat (10) @(posedge clk_i);
      #1;
      check("t4_frames", 64'(frame_dones - fd0), 64'(1));
      check("t4_starts", 64'(core_starts - cs0), 64'(4));
      check("t4_pix_q_empty", 64'(pix_q.size()), 64'(0));

      // reset while waiting on pixel 2
      start_frame(M2, 32'sh0, P2, 2, 2, 16);
      seen = 0;
      for (int k = 0; k < 100 && seen < 2; k++) begin
         @(posedge clk_i);
         #1;
         if (core_start_o) seen++;
      end
      check("second_issue_seen", 64'(seen), 64'(2));
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      pix_q.delete();
      coord_q.delete();
      @(posedge clk_i); #1;
      check("mid_rst_core_start", 64'(core_start_o), 64'(0));
      check("mid_rst_x0", 64'($unsigned(core_x0_o)), 64'(0));
      check("mid_rst_y0", 64'($unsigned(core_y0_o)), 64'(0));
      check("mid_rst_max_iter", 64'(core_max_iter_o), 64'(0));
      check("mid_rst_pix", 64'({pix_valid_o, cur}), 64'(0));
      check("mid_rst_busy_done", 64'({busy_o, frame_done_o}), 64'(0));
      rst_i = 1'b0;

      // 3x1 frame from origin with zero iteration limit
      fd0 = frame_dones;
      start_frame(32'sh0, 32'sh0, 32'sh00400000, 3, 1, 0);
      wait_frame_done(100);
      @(posedge clk_i); #1;
      check("t6_frames", 64'(frame_dones - fd0), 64'(1));
      check("t6_pix_q_empty", 64'(pix_q.size()), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
